// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with req/ack data bus and MEM/WB register
module mem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr_reg_i,
  input  logic        mem_we_reg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        d_req_o,
  output logic        d_we_o,
  output logic [31:0] d_addr_o,
  output logic [3:0]  d_sel_o,
  output logic [31:0] d_wdata_o,
  input  logic        d_ack_i,
  input  logic [31:0] d_rdata_i,
  output logic        stall_req_o,
  output logic [4:0]  wb_waddr_reg_o,
  output logic        wb_we_reg_o,
  output logic [31:0] wb_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hold, hold_n;
  logic             err, err_n;
  logic             d_req_n, d_we_n;
  logic [31:0]      d_addr_n, d_wdata_n;
  logic [3:0]       d_sel_n;
  logic [4:0]       wb_waddr_n;
  logic             wb_we_n;
  logic [31:0]      wb_wdata_n;
  logic             misalign_n, bus_err_n;

  logic        is_load, is_store, is_mem, is_byte, is_half, is_word, misal;
  logic [3:0]  sel;
  logic [31:0] st_data, ld_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    is_store = (mem_op_i >= 4'd9) && (mem_op_i <= 4'd11);
    is_mem   = is_load || is_store;
    is_byte  = (mem_op_i == 4'd1) || (mem_op_i == 4'd2) || (mem_op_i == 4'd9);
    is_half  = (mem_op_i == 4'd3) || (mem_op_i == 4'd4) || (mem_op_i == 4'd10);
    is_word  = (mem_op_i == 4'd5) || (mem_op_i == 4'd11);
    misal    = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24]
  always_comb begin
    sel     = 4'b1111;
    st_data = mem_sdata_i;
    if (is_byte) begin
      sel     = 4'b1000 >> mem_addr_i[1:0];
      st_data = {4{mem_sdata_i[7:0]}};
    end else if (is_half) begin
      sel     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      st_data = {2{mem_sdata_i[15:0]}};
    end
  end

  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_byte = d_rdata_i[31:24];
      2'd1:    ld_byte = d_rdata_i[23:16];
      2'd2:    ld_byte = d_rdata_i[15:8];
      default: ld_byte = d_rdata_i[7:0];
    endcase
    ld_half = mem_addr_i[1] ? d_rdata_i[15:0] : d_rdata_i[31:16];
    case (mem_op_i)
      4'd1:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      4'd2:    ld_fmt = {24'h0, ld_byte};
      4'd3:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      4'd4:    ld_fmt = {16'h0, ld_half};
      default: ld_fmt = d_rdata_i;
    endcase
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hold_n      = hold;
    err_n       = err;
    d_req_n     = d_req_o;
    d_we_n      = d_we_o;
    d_addr_n    = d_addr_o;
    d_sel_n     = d_sel_o;
    d_wdata_n   = d_wdata_o;
    wb_waddr_n  = wb_waddr_reg_o;
    wb_we_n     = wb_we_reg_o;
    wb_wdata_n  = wb_wdata_o;
    misalign_n  = 1'b0;
    bus_err_n   = 1'b0;
    stall_req_o = 1'b0;
    case (state)
      IDLE: begin
        wb_waddr_n = mem_waddr_reg_i;
        wb_wdata_n = mem_wdata_i;
        if (!is_mem) begin
          wb_we_n = mem_we_reg_i;
        end else if (misal) begin
          wb_we_n    = 1'b0;
          misalign_n = 1'b1;
        end else begin
          stall_req_o = 1'b1;
          wb_we_n     = 1'b0;
          d_req_n     = 1'b1;
          d_we_n      = is_store;
          d_addr_n    = {mem_addr_i[31:2], 2'b00};
          d_sel_n     = sel;
          d_wdata_n   = st_data;
          cnt_n       = '0;
          err_n       = 1'b0;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        wb_we_n     = 1'b0;
        if (d_ack_i && d_req_o) begin
          d_req_n = 1'b0;
          hold_n  = ld_fmt;
          state_n = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          d_req_n = 1'b0;
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        wb_waddr_n = mem_waddr_reg_i;
        wb_wdata_n = is_load ? hold : mem_wdata_i;
        if (err) begin
          wb_we_n   = 1'b0;
          bus_err_n = 1'b1;
        end else begin
          wb_we_n = mem_we_reg_i;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      hold           <= '0;
      err            <= 1'b0;
      d_req_o        <= 1'b0;
      d_we_o         <= 1'b0;
      d_addr_o       <= '0;
      d_sel_o        <= '0;
      d_wdata_o      <= '0;
      wb_waddr_reg_o <= '0;
      wb_we_reg_o    <= 1'b0;
      wb_wdata_o     <= '0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      hold           <= hold_n;
      err            <= err_n;
      d_req_o        <= d_req_n;
      d_we_o         <= d_we_n;
      d_addr_o       <= d_addr_n;
      d_sel_o        <= d_sel_n;
      d_wdata_o      <= d_wdata_n;
      wb_waddr_reg_o <= wb_waddr_n;
      wb_we_reg_o    <= wb_we_n;
      wb_wdata_o     <= wb_wdata_n;
      misalign_o     <= misalign_n;
      bus_err_o      <= bus_err_n;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_waddr_reg_i;
  logic        mem_we_reg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        d_req_o, d_we_o;
  logic [31:0] d_addr_o, d_wdata_o;
  logic [3:0]  d_sel_o;
  logic        d_ack_i;
  logic [31:0] d_rdata_i;
  logic        stall_req_o;
  logic [4:0]  wb_waddr_reg_o;
  logic        wb_we_reg_o;
  logic [31:0] wb_wdata_o;
  logic        misalign_o, bus_err_o;

  int n_pass = 0;
  int n_total = 0;

  // Snapshot of one access, filled by run_access
  int          stall_cnt;
  logic        busy_we, busy_wbwe, done_req;
  logic [31:0] busy_addr, busy_wdata;
  logic [3:0]  busy_sel;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .mem_waddr_reg_i(mem_waddr_reg_i), .mem_we_reg_i(mem_we_reg_i),
    .mem_wdata_i(mem_wdata_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .d_req_o(d_req_o), .d_we_o(d_we_o), .d_addr_o(d_addr_o),
    .d_sel_o(d_sel_o), .d_wdata_o(d_wdata_o),
    .d_ack_i(d_ack_i), .d_rdata_i(d_rdata_i),
    .stall_req_o(stall_req_o),
    .wb_waddr_reg_o(wb_waddr_reg_o), .wb_we_reg_o(wb_we_reg_o),
    .wb_wdata_o(wb_wdata_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    mem_op_i        = op;
    mem_addr_i      = addr;
    mem_sdata_i     = sdata;
    mem_waddr_reg_i = 5'd7;
    mem_we_reg_i    = 1'b1;
    mem_wdata_i     = 32'h5555_5555;
    #1;
  endtask

  // Ack arrives in BUSY cycle n_ack (1 = first BUSY cycle); returns after the wb_* update
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata, input int n_ack);
    set_op(op, addr, sdata);
    stall_cnt = 0;
    if (stall_req_o) stall_cnt++;
    step();
    busy_we    = d_we_o;
    busy_addr  = d_addr_o;
    busy_sel   = d_sel_o;
    busy_wdata = d_wdata_o;
    busy_wbwe  = wb_we_reg_o;
    for (int k = 1; k <= n_ack; k++) begin
      if (stall_req_o) stall_cnt++;
      if (k == n_ack) begin
        d_ack_i   = 1'b1;
        d_rdata_i = rdata;
      end
      step();
      d_ack_i = 1'b0;
    end
    done_req = d_req_o;
    if (stall_req_o) stall_cnt++;
    step();
    mem_op_i = 4'd0;
    #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; d_ack_i = 1'b0; d_rdata_i = '0;
    mem_op_i = 4'd0; mem_addr_i = '0; mem_sdata_i = '0;
    mem_waddr_reg_i = '0; mem_we_reg_i = 1'b0; mem_wdata_i = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_req", d_req_o, 0);
    check("rst_wbwe", wb_we_reg_o, 0);
    check("rst_waddr", wb_waddr_reg_o, 0);
    check("rst_wdata", wb_wdata_o, 0);
    check("rst_flags", {misalign_o, bus_err_o, stall_req_o}, 0);

    // Non-memory op passes through in one cycle without stalling
    mem_op_i = 4'd0; mem_waddr_reg_i = 5'd5; mem_we_reg_i = 1'b1; mem_wdata_i = 32'h1234;
    #1;
    check("none_stall0", stall_req_o, 0);
    step();
    check("none_wb", {wb_waddr_reg_o, wb_we_reg_o, wb_wdata_o}, {5'd5, 1'b1, 32'h1234});
    check("none_stall1", stall_req_o, 0);

    run_access(4'd1, 32'h101, 32'h0, 32'h00F0_0000, 2);
    check("lb_sel", busy_sel, 4'b0100);
    check("lb_addr", busy_addr, 32'h100);
    check("lb_we", busy_we, 0);
    check("lb_bubble", busy_wbwe, 0);
    check("lb_stall", stall_cnt, 3);
    check("lb_reqdrop", done_req, 0);
    check("lb_wdata", wb_wdata_o, 32'hFFFF_FFF0);
    check("lb_wbwe", {wb_waddr_reg_o, wb_we_reg_o}, {5'd7, 1'b1});

    run_access(4'd2, 32'h101, 32'h0, 32'h00F0_0000, 2);
    check("lbu_wdata", wb_wdata_o, 32'h0000_00F0);
    check("lbu_stall", stall_cnt, 3);

    run_access(4'd10, 32'h202, 32'hABCD, 32'h0, 1);
    check("sh_we", busy_we, 1);
    check("sh_addr", busy_addr, 32'h200);
    check("sh_sel", busy_sel, 4'b0011);
    check("sh_data", busy_wdata, 32'hABCD_ABCD);
    check("sh_reqdrop", done_req, 0);
    check("sh_wb", {wb_we_reg_o, wb_wdata_o}, {1'b1, 32'h5555_5555});
    check("sh_stall", stall_cnt, 2);

    run_access(4'd9, 32'h3, 32'h1234_56A5, 32'h0, 1);
    check("sb_sel", busy_sel, 4'b0001);
    check("sb_data", busy_wdata, 32'hA5A5_A5A5);

    run_access(4'd3, 32'h2, 32'h0, 32'h1234_8001, 1);
    check("lh_sel", busy_sel, 4'b0011);
    check("lh_wdata", wb_wdata_o, 32'hFFFF_8001);

    run_access(4'd4, 32'h0, 32'h0, 32'h8001_1234, 1);
    check("lhu_wdata", wb_wdata_o, 32'h0000_8001);

    run_access(4'd5, 32'h10, 32'h0, 32'h89AB_CDEF, 1);
    check("lw_sel", busy_sel, 4'b1111);
    check("lw_wdata", wb_wdata_o, 32'h89AB_CDEF);
    check("lw_minlat", stall_cnt, 2);

    // Misaligned word: no bus activity, one-cycle misalign pulse
    set_op(4'd5, 32'h3, 32'h0);
    check("mis_stall", stall_req_o, 0);
    step();
    check("mis_pulse", misalign_o, 1);
    check("mis_wbwe", wb_we_reg_o, 0);
    check("mis_req", d_req_o, 0);
    mem_op_i = 4'd0;
    step();
    check("mis_pulse_end", misalign_o, 0);

    // Timeout: no ack for TIMEOUT BUSY cycles
    set_op(4'd5, 32'h40, 32'h0);
    step();
    cyc = 0;
    while (d_req_o && cyc < 40) begin
      cyc++;
      step();
    end
    check("to_cycles", cyc, 16);
    check("to_reqdrop", d_req_o, 0);
    step();
    check("to_buserr", bus_err_o, 1);
    check("to_wbwe", wb_we_reg_o, 0);
    mem_op_i = 4'd0;
    #1;
    check("to_idle_stall", stall_req_o, 0);
    step();
    check("to_buserr_end", bus_err_o, 0);
    check("to_idle_req", d_req_o, 0);

    // Reset during BUSY with a coincident ack
    set_op(4'd5, 32'h80, 32'h0);
    step();
    check("rb_req", d_req_o, 1);
    rst = 1'b1; d_ack_i = 1'b1; d_rdata_i = 32'hCAFE_F00D; mem_op_i = 4'd0;
    step();
    rst = 1'b0; d_ack_i = 1'b0;
    #1;
    check("rb_req0", d_req_o, 0);
    check("rb_wb", {wb_waddr_reg_o, wb_we_reg_o, wb_wdata_o}, 38'h0);
    check("rb_flags", {misalign_o, bus_err_o, stall_req_o}, 0);
    mem_waddr_reg_i = 5'd3; mem_we_reg_i = 1'b1; mem_wdata_i = 32'h77;
    step();
    check("rb_idle_pass", {wb_waddr_reg_o, wb_we_reg_o, wb_wdata_o}, {5'd3, 1'b1, 32'h77});
    check("rb_idle_req", d_req_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
